fmul_round_pack: RTL and testbench
==================================

Name: fmul_round_pack

Overview:
- Pipelined rounding and packing stage placed directly downstream of the single-precision multiplier core.
- Consumes the raw product from the multiplier core:
  - sign;
  - 10-bit biased exponent sum (e1+e2-127);
  - unrounded 48-bit significand product;
  - special-case class.
- Normalizes the product, applies the RISC-V rounding modes and handles subnormal, overflow and NaN cases.
- Emits the IEEE-754 binary32 result plus fflags through a valid/ready elastic 2-stage pipeline.

Parameters:
- SHIFT_CAP, 26, maximum denormalizing right shift; larger shifts collapse the significand into sticky.

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of both stages
- in_valid  in  1  product valid
- in_ready  out  1  stage can accept
- in_sign  in  1  product sign
- in_exp  in  10  two's-complement biased exponent (e1+e2-127)
- in_flac  in  48  {1,f1}*{1,f2}; bit47 or bit46 set when class is FIN
- in_class  in  3  fp_pkg::fclass_t: FIN, ZERO, INF, QNAN, INVALID
- in_rm  in  3  RISC-V rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_f  out  32  binary32 result
- out_fflags  out  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset: all outputs are driven from stage registers, so they are 0 in reset, except in_ready.
  - s1_valid, s2_valid, out_valid, out_f and out_fflags are 0.
  - in_ready is combinational: in_ready = !s1_valid || s1_adv, giving 1 in reset.
- Pipeline and handshake:
  - s2_adv = !s2_valid || out_ready; s1_adv = s2_adv.
  - Latency is 2 cycles with no backpressure; throughput is 1/cycle.
  - A stalled stage holds its contents.
  - out_f and out_fflags stay stable while out_valid && !out_ready.
- S1, normalize and denormalize:
  - If flac[47]: exp+1, mant=flac[47:24], g=flac[23], s=|flac[22:0].
  - Else: mant=flac[46:23], g=flac[22], s=|flac[21:0].
  - If norm exp <= 0 (signed): shift mant right by min(1-exp, SHIFT_CAP) through g into sticky; exp=0 and tiny=1.
  - S1 registers sign, exp(10), mant(24), g, s, tiny, class and rm.
- S2, round and pack:
  - inc is selected by rm:
    - RNE: g&(s|lsb).
    - RTZ: 0.
    - RDN: sign&(g|s).
    - RUP: !sign&(g|s).
    - RMM: g.
    - rm 5-7 are treated as RNE (illegal rm is trapped by the decoder).
  - mant+inc carry out of bit 23 → exp+1 and mant>>1.
  - A subnormal that rounds to mant[23]=1 becomes exp 1.
  - NX = g|s.
  - UF = tiny & NX.
- Overflow (rounded exp >= 255, signed): OF|NX set.
  - Result is inf, except RTZ, RDN with +, or RUP with −, which give max finite 0x7F7FFFFF with the sign applied.
- Class override, applied in S2 (no rounding, zero flags unless stated):
  - ZERO → {sign,31'b0}.
  - INF → {sign,0xFF,0}.
  - QNAN → 0x7FC00000.
  - INVALID (sNaN input or inf*0) → 0x7FC00000 with NV.
- Flush:
  - Clears s1_valid and s2_valid next edge, regardless of out_ready.
  - An input accepted in the same cycle as flush is dropped.
- Reset mid-operation: in-flight results are discarded; no partial output.

Decomposition:
- fp_pkg holds:
  - fclass_t enum;
  - rm_t enum;
  - fflag bit index constants;
  - CANON_NAN = 32'h7FC00000;
  - BIAS = 127;
  - EXP_MAX = 255.
- One sub-module, fp_round_inc: combinational rm/sign/lsb/g/s → inc. It is reused by future FADD/FDIV rounding.

Test Plan:
- 1.5*1.5: in_exp=127, in_flac=0x900000000000, RNE → 2 cycles later out_f=0x40100000, fflags=0.
- Tie rounding: mant lsb=0, g=1, s=0, exp 127, sign 0.
  - RNE → mantissa unchanged.
  - RUP → mantissa+1.
  - Both give NX=1 (fflags=0x01).
- All-ones carry: mant=0xFFFFFF, g=1, RNE, exp 127 → out_f=0x40000000, NX.
- Overflow: in_exp=254, flac[47]=1.
  - RNE → 0x7F800000, fflags=0x05.
  - RTZ → 0x7F7FFFFF, fflags=0x05.
- Subnormal: in_exp=0, flac=0x400000000000 → 0x00400000, fflags=0. Same input with flac bit0 set → UF|NX=0x03.
- Special cases and control:
  - INVALID class → 0x7FC00000, fflags=0x10.
  - 3 back-to-back inputs with out_ready held low 4 cycles: in_ready drops after 2 are accepted, out_f stays stable, all 3 results arrive in order.
  - flush with both stages full → out_valid=0 next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 types and constants for the FP datapath stages.
package fp_pkg;
  typedef enum logic [2:0] {
    FIN     = 3'd0,
    ZERO    = 3'd1,
    INF     = 3'd2,
    QNAN    = 3'd3,
    INVALID = 3'd4
  } fclass_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_t;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Normalized/denormalized product held between the two stages.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        g;
    logic        s;
    logic        tiny;
    logic [2:0]  cls;
    logic [2:0]  rm;
  } s1_t;
endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision shared by the FP rounding stages.
module fp_round_inc
  import fp_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       inc
);
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = !sign & (g | s);
      RM_RMM:  inc = g;
      // unused encodings fall back to round-to-nearest-even
      default: inc = g & (s | lsb);
    endcase
  end
endmodule

// File: rtl/fmul_round_pack.sv
// Two-stage elastic round/pack for the fp32 multiplier: S1 normalizes and
// denormalizes the raw product, S2 rounds, detects overflow and packs.
module fmul_round_pack
  import fp_pkg::*;
#(
  parameter int SHIFT_CAP = 26
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_flac,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_f,
  output logic [4:0]  out_fflags
);
  localparam int VW = 25 + SHIFT_CAP;
  localparam int SW = $clog2(SHIFT_CAP + 1);
  localparam logic signed [11:0] CAP12  = 12'(SHIFT_CAP);
  localparam logic [SW-1:0]      CAP_SH = SW'(SHIFT_CAP);

  logic [2:1] vld_pipe;
  logic       s1_adv, s2_adv;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = s2_adv;
  assign in_ready  = !vld_pipe[1] || s1_adv;
  assign out_valid = vld_pipe[2];

  // ---------------- S1: normalize / denormalize ----------------
  s1_t                s1_d, s1_q;
  logic signed [10:0] n_exp;
  logic signed [11:0] sh_raw;
  logic [23:0]        n_mant;
  logic               n_g, n_s;
  logic [SW-1:0]      sh;
  logic [VW-1:0]      sh_vec;

  always_comb begin
    if (in_flac[47]) begin
      n_exp  = $signed({in_exp[9], in_exp}) + 11'sd1;
      n_mant = in_flac[47:24];
      n_g    = in_flac[23];
      n_s    = |in_flac[22:0];
    end else begin
      n_exp  = $signed({in_exp[9], in_exp});
      n_mant = in_flac[46:23];
      n_g    = in_flac[22];
      n_s    = |in_flac[21:0];
    end
    sh_raw = 12'sd1 - $signed({n_exp[10], n_exp});
    sh     = (sh_raw > CAP12) ? CAP_SH : sh_raw[SW-1:0];
    // guard rides along the shift; everything past it lands in sticky
    sh_vec = {n_mant, n_g, {SHIFT_CAP{1'b0}}} >> sh;

    s1_d.sign = in_sign;
    s1_d.cls  = in_class;
    s1_d.rm   = in_rm;
    if (n_exp[10] || n_exp == '0) begin
      s1_d.exp  = '0;
      s1_d.mant = sh_vec[VW-1 -: 24];
      s1_d.g    = sh_vec[SHIFT_CAP];
      s1_d.s    = n_s | (|sh_vec[SHIFT_CAP-1:0]);
      s1_d.tiny = 1'b1;
    end else begin
      s1_d.exp  = n_exp[9:0];
      s1_d.mant = n_mant;
      s1_d.g    = n_g;
      s1_d.s    = n_s;
      s1_d.tiny = 1'b0;
    end
  end

  // ---------------- S2: round / pack ----------------
  logic        inc, carry, nx, ovf, max_fin;
  logic [24:0] mant_sum;
  logic [23:0] mant_r;
  logic [10:0] exp_r;
  logic [31:0] f_d;
  logic [4:0]  ff_d;

  fp_round_inc u_inc (
    .rm   (s1_q.rm),
    .sign (s1_q.sign),
    .lsb  (s1_q.mant[0]),
    .g    (s1_q.g),
    .s    (s1_q.s),
    .inc  (inc)
  );

  always_comb begin
    mant_sum = {1'b0, s1_q.mant} + {24'b0, inc};
    carry    = mant_sum[24];
    mant_r   = carry ? mant_sum[24:1] : mant_sum[23:0];
    // a subnormal rounding up into the hidden bit becomes the smallest normal
    exp_r    = {1'b0, s1_q.exp} + {10'b0, carry}
             + {10'b0, (s1_q.exp == '0) && mant_r[23]};
    nx       = s1_q.g | s1_q.s;
    ovf      = exp_r >= 11'(EXP_MAX);
    max_fin  = (s1_q.rm == RM_RTZ) || (s1_q.rm == RM_RDN && !s1_q.sign)
            || (s1_q.rm == RM_RUP && s1_q.sign);
    f_d      = '0;
    ff_d     = '0;
    case (s1_q.cls)
      ZERO:    f_d = {s1_q.sign, 31'b0};
      INF:     f_d = {s1_q.sign, 8'hFF, 23'b0};
      QNAN:    f_d = CANON_NAN;
      INVALID: begin
        f_d         = CANON_NAN;
        ff_d[FF_NV] = 1'b1;
      end
      default: begin
        if (ovf) begin
          f_d         = max_fin ? {s1_q.sign, 31'h7F7F_FFFF} : {s1_q.sign, 8'hFF, 23'b0};
          ff_d[FF_OF] = 1'b1;
          ff_d[FF_NX] = 1'b1;
        end else begin
          f_d         = {s1_q.sign, exp_r[7:0], mant_r[22:0]};
          ff_d[FF_NX] = nx;
          ff_d[FF_UF] = s1_q.tiny & nx;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      out_f      <= '0;
      out_fflags <= '0;
    end else begin
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        if (s2_adv)   vld_pipe[2] <= vld_pipe[1];
        if (in_ready) vld_pipe[1] <= in_valid;
      end
      if (in_ready && in_valid) s1_q <= s1_d;
      if (s2_adv && vld_pipe[1]) begin
        out_f      <= f_d;
        out_fflags <= ff_d;
      end
    end
  end
endmodule

// File: tb/tb_fmul_round_pack.sv
// Random + directed bench for fmul_round_pack against an exact-arithmetic rounding model.
module tb_fmul_round_pack;
  logic        CLK, RSTn, flush, in_valid, in_ready, in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_flac;
  logic [2:0]  in_class, in_rm;
  logic        out_valid, out_ready;
  logic [31:0] out_f;
  logic [4:0]  out_fflags;

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];
  bit          ovr = 0;
  logic [36:0] ovr_val;

  fmul_round_pack #(.SHIFT_CAP(26)) dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_flac(in_flac), .in_class(in_class), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_fflags(out_fflags)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value = flac * 2^(exp-127-46); round to the binary32 grid with integer arithmetic.
  function automatic void ref_model(input logic sg, input logic [9:0] e10, input logic [47:0] f,
                                    input logic [2:0] cls, input logic [2:0] rm,
                                    output logic [31:0] r, output logic [4:0] fl);
    int e, p, biased, k, rcls;
    longint unsigned fv, keep, rem, half;
    bit up, tiny, nx;
    r = 0; fl = 0;
    case (cls)
      3'd1: begin r = {sg, 31'b0}; return; end
      3'd2: begin r = {sg, 8'hFF, 23'b0}; return; end
      3'd3: begin r = 32'h7FC00000; return; end
      3'd4: begin r = 32'h7FC00000; fl = 5'h10; return; end
      default: ;
    endcase
    e = int'($signed(e10));
    fv = 64'(f);
    p = f[47] ? 47 : 46;
    biased = e + p - 46;
    tiny = (biased <= 0);
    k = tiny ? (24 - e) : (p - 23);
    if (k >= 49) begin
      keep = 0;
      rcls = (fv == 0) ? 0 : 1;
    end else begin
      keep = fv >> k;
      rem  = fv - (keep << k);
      half = 64'd1 << (k - 1);
      rcls = (rem == 0) ? 0 : (rem < half) ? 1 : (rem == half) ? 2 : 3;
    end
    case (rm)
      3'd1:    up = 0;
      3'd2:    up = sg && rcls != 0;
      3'd3:    up = !sg && rcls != 0;
      3'd4:    up = rcls >= 2;
      default: up = (rcls == 3) || (rcls == 2 && keep[0]);
    endcase
    keep = keep + 64'(up);
    nx = (rcls != 0);
    if (!tiny) begin
      if (keep == (64'd1 << 24)) begin
        keep = keep >> 1;
        biased++;
      end
      if (biased >= 255) begin
        fl = 5'h05;
        if (rm == 3'd1 || (rm == 3'd2 && !sg) || (rm == 3'd3 && sg)) r = {sg, 31'h7F7FFFFF};
        else r = {sg, 8'hFF, 23'b0};
        return;
      end
      r = {sg, 8'(biased), 23'(keep)};
    end else begin
      r = {sg, (keep >= (64'd1 << 23)) ? 8'd1 : 8'd0, 23'(keep)};
    end
    fl = {3'b0, tiny && nx, nx};
  endfunction

  // One clock of stimulus; output checks and scoreboard updates happen mid-cycle.
  task automatic cyc(input bit v, input bit sg, input logic [9:0] e, input logic [47:0] f,
                     input logic [2:0] c, input logic [2:0] rm, input bit ordy, input bit fl);
    logic [31:0] r;
    logic [4:0]  rf;
    @(negedge CLK);
    in_valid = v; in_sign = sg; in_exp = e; in_flac = f; in_class = c; in_rm = rm;
    out_ready = ordy; flush = fl;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out", {36'b0, out_valid}, 37'd0);
      else if (out_ready) chk("result", {out_fflags, out_f}, exp_q.pop_front());
      else chk("stall_hold", {out_fflags, out_f}, exp_q[0]);
    end
    if (fl) exp_q.delete();
    else if (v && in_ready) begin
      ref_model(sg, e, f, c, rm, r, rf);
      exp_q.push_back(ovr ? ovr_val : {rf, r});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 10'd0, 48'd0, 3'd0, 3'd0, 1, 0);
  endtask

  task automatic dir_case(input bit sg, input logic [9:0] e, input logic [47:0] f,
                          input logic [2:0] c, input logic [2:0] rm,
                          input logic [31:0] wf, input logic [4:0] wff);
    ovr = 1; ovr_val = {wff, wf};
    cyc(1, sg, e, f, c, rm, 1, 0);
    ovr = 0;
    idle(3);
  endtask

  task automatic rand_txn(input bit v, input bit ordy, input bit fl);
    logic [47:0] f;
    logic [2:0]  c;
    f = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) f[47] = 1'b1;
    else begin f[47] = 1'b0; f[46] = 1'b1; end
    if ($urandom_range(0, 3) == 0) f[23:0] = '0;
    c = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(1, 4));
    cyc(v, 1'($urandom), 10'($urandom_range(0, 330) - 50), f, c, 3'($urandom_range(0, 7)), ordy, fl);
  endtask

  initial begin
    RSTn = 0; flush = 0; in_valid = 0; in_sign = 0; in_exp = 0; in_flac = 0;
    in_class = 0; in_rm = 0; out_ready = 1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_out_valid", {36'b0, out_valid}, 37'd0);
    chk("rst_out", {out_fflags, out_f}, 37'd0);
    chk("rst_in_ready", {36'b0, in_ready}, 37'd1);
    RSTn = 1;

    // latency: result appears after two edges
    ovr = 1; ovr_val = {5'h00, 32'h40100000};
    cyc(1, 0, 10'd127, 48'h900000000000, 3'd0, 3'd0, 1, 0);
    ovr = 0;
    cyc(0, 0, 10'd0, 48'd0, 3'd0, 3'd0, 1, 0);
    chk("lat_early", {36'b0, out_valid}, 37'd0);
    cyc(0, 0, 10'd0, 48'd0, 3'd0, 3'd0, 1, 0);
    chk("lat_queue", 37'(exp_q.size()), 37'd0);
    idle(1);

    dir_case(0, 10'd127, 48'h400000400000, 3'd0, 3'd0, 32'h3F800000, 5'h01);
    dir_case(0, 10'd127, 48'h400000400000, 3'd0, 3'd3, 32'h3F800001, 5'h01);
    dir_case(0, 10'd126, 48'hFFFFFF800000, 3'd0, 3'd0, 32'h40000000, 5'h01);
    dir_case(0, 10'd254, 48'h800000000000, 3'd0, 3'd0, 32'h7F800000, 5'h05);
    dir_case(0, 10'd254, 48'h800000000000, 3'd0, 3'd1, 32'h7F7FFFFF, 5'h05);
    dir_case(0, 10'd0,   48'h400000000000, 3'd0, 3'd0, 32'h00400000, 5'h00);
    dir_case(0, 10'd0,   48'h400000000001, 3'd0, 3'd0, 32'h00400000, 5'h03);
    dir_case(0, 10'd0,   48'h800000000000, 3'd4, 3'd0, 32'h7FC00000, 5'h10);
    dir_case(1, 10'd5,   48'h800000000000, 3'd1, 3'd0, 32'h80000000, 5'h00);

    // backpressure: 3 back-to-back with consumer stalled 4 cycles
    cyc(1, 0, 10'd127, 48'h900000000000, 3'd0, 3'd0, 0, 0);
    cyc(1, 1, 10'd100, 48'hC00000000001, 3'd0, 3'd2, 0, 0);
    cyc(1, 0, 10'd130, 48'h500000000000, 3'd0, 3'd4, 0, 0);
    chk("bp_in_ready", {36'b0, in_ready}, 37'd0);
    cyc(1, 0, 10'd130, 48'h500000000000, 3'd0, 3'd4, 0, 0);
    chk("bp_in_ready2", {36'b0, in_ready}, 37'd0);
    cyc(1, 0, 10'd130, 48'h500000000000, 3'd0, 3'd4, 1, 0);
    idle(4);
    chk("bp_drain", 37'(exp_q.size()), 37'd0);

    // flush with both stages full
    cyc(1, 0, 10'd127, 48'h900000000000, 3'd0, 3'd0, 0, 0);
    cyc(1, 0, 10'd128, 48'h900000000000, 3'd0, 3'd0, 0, 0);
    cyc(1, 0, 10'd129, 48'h900000000000, 3'd0, 3'd0, 0, 1);
    cyc(0, 0, 10'd0, 48'd0, 3'd0, 3'd0, 1, 0);
    chk("flush_out_valid", {36'b0, out_valid}, 37'd0);
    chk("flush_in_ready", {36'b0, in_ready}, 37'd1);
    idle(2);

    // reset mid-operation
    cyc(1, 0, 10'd127, 48'h900000000000, 3'd0, 3'd0, 0, 0);
    cyc(1, 0, 10'd127, 48'h900000000000, 3'd0, 3'd0, 0, 0);
    @(negedge CLK);
    in_valid = 0; RSTn = 0;
    #1;
    chk("midrst_out_valid", {36'b0, out_valid}, 37'd0);
    exp_q.delete();
    @(negedge CLK);
    RSTn = 1;
    idle(2);

    for (int i = 0; i < 600; i++)
      rand_txn($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    chk("final_drain", 37'(exp_q.size()), 37'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
